// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, widths and default latencies.
package md_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Latency counter width; both latencies must fit.
    localparam int MD_CNT_W = 8;

    function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath for mult/multu/div/divu producing the 64-bit {p_hi,p_lo} result.
module md_arith
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic [31:0]        p_hi,
    output logic [31:0]        p_lo,
    output logic               div0
);

    logic        sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Division works on magnitudes; signs are restored so the quotient truncates toward
    // zero and the remainder follows the dividend. A zero divisor is forced to 1 so the
    // datapath never produces X; the div0 flag tells the top to discard the result.
    always_comb begin
        sgn     = md_is_signed(op);
        a_ext   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        b_ext   = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        product = a_ext * b_ext;

        a_neg   = sgn & a[31];
        b_neg   = sgn & b[31];
        a_mag   = a_neg ? (32'd0 - a) : a;
        b_mag   = b_neg ? (32'd0 - b) : b;
        div0    = md_is_div(op) && (b == 32'd0);
        divisor = (b == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;

        if (md_is_div(op)) begin
            p_hi = rem;
            p_lo = quot;
        end else begin
            p_hi = product[63:32];
            p_lo = product[31:0];
        end
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div, single-cycle mthi/mtlo.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        md_a,
    input  logic [31:0]        md_b,
    input  logic               hilo_sel,
    output logic               busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo,
    output logic [31:0]        md_hi_lo
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    logic [MD_CNT_W-1:0] counter;
    logic [31:0]         p_hi_q;
    logic [31:0]         p_lo_q;
    logic                div0_q;
    logic [31:0]         ar_hi;
    logic [31:0]         ar_lo;
    logic                ar_div0;

    md_arith u_arith (
        .op   (md_op),
        .a    (md_a),
        .b    (md_b),
        .p_hi (ar_hi),
        .p_lo (ar_lo),
        .div0 (ar_div0)
    );

    // The result is latched at accept and only committed to HI/LO on the final busy
    // edge, so HI/LO keep their old values for the whole latency window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            counter <= '0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
            div0_q  <= 1'b0;
        end else if (busy) begin
            if (counter == MD_CNT_W'(1)) begin
                busy    <= 1'b0;
                counter <= '0;
                if (!div0_q) begin
                    hi <= p_hi_q;
                    lo <= p_lo_q;
                end
            end else begin
                counter <= counter - MD_CNT_W'(1);
            end
        end else if (op_valid) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    p_hi_q  <= ar_hi;
                    p_lo_q  <= ar_lo;
                    div0_q  <= 1'b0;
                    counter <= MULT_LOAD;
                    busy    <= 1'b1;
                end
                MD_DIV, MD_DIVU: begin
                    p_hi_q  <= ar_hi;
                    p_lo_q  <= ar_lo;
                    div0_q  <= ar_div0;
                    counter <= DIV_LOAD;
                    busy    <= 1'b1;
                end
                MD_MTHI: hi <= md_a;
                MD_MTLO: lo <= md_a;
                default: ;
            endcase
        end
    end

    // The hazard unit must stall MD ops in D while busy; an op arriving here is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(op_valid && busy))
                else $warning("md_unit: op_valid while busy, op %0d ignored", md_op);
        end
    end

    assign md_hi_lo = hilo_sel ? hi : lo;

endmodule
